// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction-register load path.
// Word geometry, IR strobe code and fetch FSM states.
package contants;
  localparam int WORD_SIZE    = 19;
  localparam int OPCODE_WIDTH = 5;
  localparam int ADDR_WIDTH   = WORD_SIZE - OPCODE_WIDTH;
  localparam int LOAD_IR      = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    HOLD   = 2'd2
  } fetch_state_t;

  function automatic logic [ADDR_WIDTH-1:0] pc_next(
    input logic [ADDR_WIDTH-1:0] pc
  );
    return pc + 1'b1;
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: control, program memory and IR handshakes.
// master = fetch unit, slave = its environment.
interface instruction_fetch_unit_if #(
  parameter int CNT_WIDTH = 16
);
  import contants::*;

  logic                  fetch_en;
  logic                  branch_valid;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [WORD_SIZE-1:0]  mem_rdata;
  logic                  mem_ready;
  logic [WORD_SIZE-1:0]  INSTR;
  logic                  instr_valid;
  logic                  instr_ack;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  fetch_count;

  modport master (
    input  fetch_en, branch_valid, branch_target,
    input  mem_rdata, mem_ready, instr_ack,
    output mem_addr, mem_rd, INSTR, instr_valid,
    output pc, busy, fetch_count
  );

  modport slave (
    output fetch_en, branch_valid, branch_target,
    output mem_rdata, mem_ready, instr_ack,
    input  mem_addr, mem_rd, INSTR, instr_valid,
    input  pc, busy, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter: branch load beats increment, wraps at top.
// Holds when neither strobe is active.
module program_counter
  import contants::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = target_i;
    else if (inc_i)
      pc_d = pc_next(pc_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads program memory at the PC and
// hands words to the IR over a valid/ack handshake.
module instruction_fetch_unit
  import contants::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter int                    CNT_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  instruction_fetch_unit_if.master  bus
);
  fetch_state_t          state_q, state_d;
  logic                  flush_q, flush_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  pc_inc;
  logic [ADDR_WIDTH-1:0] pc;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (bus.branch_valid),
    .target_i (bus.branch_target),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    pc_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.fetch_en && !bus.branch_valid) begin
          state_d = MEM_RD;
          rd_d    = 1'b1;
          addr_d  = pc;
        end
      end
      MEM_RD: begin
        // A branch during the wait cannot cancel the bus
        // read; the flag discards its data on completion.
        if (bus.mem_ready) begin
          rd_d    = 1'b0;
          flush_d = 1'b0;
          state_d = IDLE;
          if (!flush_q && !bus.branch_valid) begin
            instr_d = bus.mem_rdata;
            valid_d = 1'b1;
            pc_inc  = 1'b1;
            state_d = HOLD;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
        end else if (bus.branch_valid) begin
          flush_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.branch_valid) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (bus.instr_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (bus.fetch_en) begin
            state_d = MEM_RD;
            rd_d    = 1'b1;
            addr_d  = pc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_rd      = rd_q;
  assign bus.mem_addr    = addr_q;
  assign bus.INSTR       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_count = cnt_q;
  assign bus.busy        = busy_q;
  assign bus.pc          = pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a
// random phase, all checked against a transaction-level model.
module tb_instruction_fetch_unit;
  import contants::*;

  logic CLK;
  logic RST;
  int   n_chk;
  int   n_fail;
  bit   chk_on;

  instruction_fetch_unit_if #(.CNT_WIDTH(16)) ifc ();
  instruction_fetch_unit_if #(.CNT_WIDTH(3))  sifc ();

  instruction_fetch_unit #(
    .RESET_PC  ('0),
    .CNT_WIDTH (16)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  instruction_fetch_unit #(
    .RESET_PC  ('0),
    .CNT_WIDTH (3)
  ) u_sat (
    .CLK (CLK),
    .RST (RST),
    .bus (sifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model state: an outstanding read, a word awaiting ack.
  logic                  e_rd    = 1'b0;
  logic [ADDR_WIDTH-1:0] e_addr  = '0;
  logic [WORD_SIZE-1:0]  e_instr = '0;
  logic                  e_valid = 1'b0;
  logic [ADDR_WIDTH-1:0] e_pc    = '0;
  int                    e_cnt   = 0;
  bit                    e_squash = 1'b0;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_rd = 0; e_addr = 0; e_instr = 0; e_valid = 0;
      e_pc = 0; e_cnt = 0; e_squash = 0;
    end else begin
      logic [ADDR_WIDTH-1:0] old_pc;
      old_pc = e_pc;
      if (e_rd) begin
        if (ifc.mem_ready) begin
          e_rd = 0;
          if (!e_squash && !ifc.branch_valid) begin
            e_instr = ifc.mem_rdata;
            e_valid = 1;
            e_pc    = ADDR_WIDTH'((int'(old_pc) + 1) % 16384);
            if (e_cnt < 65535) e_cnt++;
          end
          e_squash = 0;
        end else if (ifc.branch_valid) begin
          e_squash = 1;
        end
      end else if (e_valid) begin
        if (ifc.branch_valid) e_valid = 0;
        else if (ifc.instr_ack) begin
          e_valid = 0;
          if (ifc.fetch_en) begin
            e_rd = 1; e_addr = old_pc;
          end
        end
      end else if (ifc.fetch_en && !ifc.branch_valid) begin
        e_rd = 1; e_addr = old_pc;
      end
      if (ifc.branch_valid) e_pc = ifc.branch_target;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      cmp("mem_rd", 32'(ifc.mem_rd), 32'(e_rd));
      cmp("mem_addr", 32'(ifc.mem_addr), 32'(e_addr));
      cmp("instr_valid", 32'(ifc.instr_valid), 32'(e_valid));
      cmp("INSTR", 32'(ifc.INSTR), 32'(e_instr));
      cmp("pc", 32'(ifc.pc), 32'(e_pc));
      cmp("busy", 32'(ifc.busy), 32'(e_rd | e_valid));
      cmp("fetch_count", 32'(ifc.fetch_count), e_cnt);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; chk_on = 1'b1;
    RST = 1'b1;
    ifc.fetch_en = 0; ifc.branch_valid = 0;
    ifc.branch_target = '0; ifc.mem_rdata = '0;
    ifc.mem_ready = 0; ifc.instr_ack = 0;
    sifc.fetch_en = 0; sifc.branch_valid = 0;
    sifc.branch_target = '0; sifc.mem_rdata = '0;
    sifc.mem_ready = 0; sifc.instr_ack = 0;
    repeat (2) tick();
    cmp("rst_pc", 32'(ifc.pc), 0);
    cmp("rst_busy", 32'(ifc.busy), 0);
    cmp("rst_cnt", 32'(ifc.fetch_count), 0);
    RST = 1'b0;
    tick();

    // 1: single fetch with three wait states
    ifc.fetch_en = 1; tick(); ifc.fetch_en = 0;
    cmp("t1_rd", 32'(ifc.mem_rd), 1);
    cmp("t1_addr", 32'(ifc.mem_addr), 0);
    repeat (3) tick();
    ifc.mem_ready = 1; ifc.mem_rdata = 19'h2A5F3;
    tick(); ifc.mem_ready = 0;
    cmp("t1_instr", 32'(ifc.INSTR), 32'h2A5F3);
    cmp("t1_pc", 32'(ifc.pc), 1);
    cmp("t1_cnt", 32'(ifc.fetch_count), 1);
    repeat (2) tick();
    cmp("t1_hold", 32'(ifc.instr_valid), 1);
    ifc.instr_ack = 1; tick(); ifc.instr_ack = 0;
    cmp("t1_ackd", 32'(ifc.instr_valid), 0);

    // 2: four back-to-back fetches across the wrap
    RST = 1'b1; tick(); RST = 1'b0;
    ifc.branch_valid = 1; ifc.branch_target = 14'h3FFE;
    tick(); ifc.branch_valid = 0;
    ifc.fetch_en = 1; tick();
    for (int k = 0; k < 4; k++) begin
      cmp("t2_addr", 32'(ifc.mem_addr), (16382 + k) % 16384);
      ifc.mem_ready = 1; ifc.mem_rdata = 19'(k + 5);
      tick(); ifc.mem_ready = 0;
      cmp("t2_valid", 32'(ifc.instr_valid), 1);
      tick();
      ifc.instr_ack = 1;
      if (k == 3) ifc.fetch_en = 0;
      tick(); ifc.instr_ack = 0;
      cmp("t2_drop", 32'(ifc.instr_valid), 0);
    end
    cmp("t2_cnt", 32'(ifc.fetch_count), 4);
    cmp("t2_pc", 32'(ifc.pc), 2);

    // 3: branch while a read waits
    ifc.fetch_en = 1; tick(); ifc.fetch_en = 0;
    tick();
    ifc.branch_valid = 1; ifc.branch_target = 14'h0100;
    tick(); ifc.branch_valid = 0;
    cmp("t3_rdheld", 32'(ifc.mem_rd), 1);
    cmp("t3_pc", 32'(ifc.pc), 32'h100);
    tick();
    ifc.mem_ready = 1; ifc.mem_rdata = 19'h7FFFF;
    tick(); ifc.mem_ready = 0;
    cmp("t3_novalid", 32'(ifc.instr_valid), 0);
    cmp("t3_idle", 32'(ifc.busy), 0);
    cmp("t3_cnt", 32'(ifc.fetch_count), 4);
    ifc.fetch_en = 1; tick(); ifc.fetch_en = 0;
    cmp("t3_addr", 32'(ifc.mem_addr), 32'h100);
    ifc.mem_ready = 1; ifc.mem_rdata = 19'h12345;
    tick(); ifc.mem_ready = 0;
    cmp("t3_instr", 32'(ifc.INSTR), 32'h12345);

    // 4: branch coincident with ack in HOLD
    ifc.instr_ack = 1; ifc.branch_valid = 1;
    ifc.branch_target = 14'h0200;
    tick(); ifc.instr_ack = 0; ifc.branch_valid = 0;
    cmp("t4_valid", 32'(ifc.instr_valid), 0);
    cmp("t4_cnt", 32'(ifc.fetch_count), 5);
    cmp("t4_pc", 32'(ifc.pc), 32'h200);

    // 5: asynchronous reset mid-read
    ifc.fetch_en = 1; tick(); ifc.fetch_en = 0;
    tick();
    #2 RST = 1'b1;
    #1;
    cmp("t5_rd", 32'(ifc.mem_rd), 0);
    cmp("t5_pc", 32'(ifc.pc), 0);
    cmp("t5_addr", 32'(ifc.mem_addr), 0);
    cmp("t5_busy", 32'(ifc.busy), 0);
    cmp("t5_cnt", 32'(ifc.fetch_count), 0);
    tick(); RST = 1'b0;
    ifc.mem_ready = 1; ifc.mem_rdata = 19'h55555;
    repeat (2) tick(); ifc.mem_ready = 0;
    cmp("t5_late", 32'(ifc.instr_valid), 0);

    // 6: ack while idle; counter saturation on narrow copy
    ifc.instr_ack = 1; tick(); ifc.instr_ack = 0;
    cmp("t6_ackidle", 32'(ifc.busy), 0);
    for (int k = 0; k < 9; k++) begin
      sifc.fetch_en = 1; tick(); sifc.fetch_en = 0;
      sifc.mem_ready = 1; sifc.mem_rdata = 19'(k);
      tick(); sifc.mem_ready = 0;
      cmp("t6_svalid", 32'(sifc.instr_valid), 1);
      cmp("t6_sat", 32'(sifc.fetch_count), (k < 7) ? k + 1 : 7);
      sifc.instr_ack = 1; tick(); sifc.instr_ack = 0;
    end

    // random phase
    for (int c = 0; c < 3000; c++) begin
      ifc.fetch_en = ($urandom_range(0, 3) != 0);
      ifc.branch_valid = ($urandom_range(0, 9) == 0);
      ifc.branch_target = ADDR_WIDTH'($urandom);
      ifc.mem_rdata = WORD_SIZE'($urandom);
      ifc.mem_ready = ifc.mem_rd ?
        ($urandom_range(0, 2) == 0) :
        ($urandom_range(0, 4) == 0);
      ifc.instr_ack = ifc.instr_valid ?
        ($urandom_range(0, 1) == 0) :
        ($urandom_range(0, 4) == 0);
      tick();
    end
    ifc.fetch_en = 0; ifc.branch_valid = 0;
    ifc.mem_ready = 0; ifc.instr_ack = 0;
    tick();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
